// File: rtl/alu_seq_m_if.sv
// Operation request / result handshake bundle for alu_seq_m.
interface alu_seq_m_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output flush, in_valid, op, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, op, src_a, src_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/alu_seq_m.sv
// Handshaked EX-stage ALU: base integer ops in one cycle, RV32M multiply/divide
// as radix-2 iterative operations over XLEN cycles.
module alu_seq_m #(
  parameter int          XLEN       = 32,
  parameter logic [31:0] BAD_OP_VAL = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_seq_m_if.slave  bus
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ONES    = '1;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SLL  = 5'd1;
  localparam logic [4:0] OP_SLT  = 5'd2;
  localparam logic [4:0] OP_SLTU = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SRL  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_SUB  = 5'd8;
  localparam logic [4:0] OP_LUI  = 5'd9;
  localparam logic [4:0] OP_SRA  = 5'd13;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [SHW-1:0]    r_cnt;
  logic              r_is_div;
  logic              r_is_rem;
  logic              r_hi;
  logic              r_neg;

  logic [SHW-1:0]    w_shamt;
  logic [XLEN-1:0]   w_base;
  logic [XLEN-1:0]   w_direct_res;
  logic              w_is_md, w_is_div, w_is_rem, w_hi;
  logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic              w_div_zero, w_div_ovf, w_start_calc, w_accept;
  logic [XLEN:0]     w_mul_sum, w_div_shift, w_div_diff;
  logic [2*XLEN-1:0] w_step_acc, w_prod;
  logic [XLEN-1:0]   w_div_val, w_fin_res;

  assign w_shamt = bus.src_b[SHW-1:0];

  // Single-cycle base ALU; anything not decoded falls through to BAD_OP_VAL.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    w_base = XLEN'(BAD_OP_VAL);
    case (bus.op)
      OP_ADD:  w_base = bus.src_a + bus.src_b;
      OP_SLL:  w_base = bus.src_a << w_shamt;
      OP_SLT:  w_base = {{(XLEN-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
      OP_SLTU: w_base = {{(XLEN-1){1'b0}}, bus.src_a < bus.src_b};
      OP_XOR:  w_base = bus.src_a ^ bus.src_b;
      OP_SRL:  w_base = bus.src_a >> w_shamt;
      OP_OR:   w_base = bus.src_a | bus.src_b;
      OP_AND:  w_base = bus.src_a & bus.src_b;
      OP_SUB:  w_base = bus.src_a - bus.src_b;
      OP_LUI:  w_base = bus.src_a;
      OP_SRA:  w_base = $unsigned($signed(bus.src_a) >>> w_shamt);
      default: ;
    endcase
  end

  // M-extension decode: 16..19 multiply family, 20..23 divide family.
  assign w_is_md  = bus.op[4] & ~bus.op[3];
  assign w_is_div = w_is_md & bus.op[2];
  assign w_is_rem = w_is_div & bus.op[1];
  assign w_hi     = ~bus.op[2] & (bus.op[1] | bus.op[0]);
  assign w_a_sgn  = w_is_md & ((~bus.op[2] & (bus.op[1] ^ bus.op[0])) | (bus.op[2] & ~bus.op[0]));
  assign w_b_sgn  = w_is_md & ((~bus.op[2] & ~bus.op[1] & bus.op[0]) | (bus.op[2] & ~bus.op[0]));
  assign w_a_neg  = w_a_sgn & bus.src_a[XLEN-1];
  assign w_b_neg  = w_b_sgn & bus.src_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -bus.src_a : bus.src_a;
  assign w_b_mag  = w_b_neg ? -bus.src_b : bus.src_b;

  assign w_div_zero   = w_is_div & (bus.src_b == '0);
  assign w_div_ovf    = w_is_div & w_a_sgn & (bus.src_a == MIN_VAL) & (bus.src_b == ONES);
  assign w_start_calc = w_is_md & ~w_div_zero & ~w_div_ovf;
  assign w_accept     = bus.in_valid & r_in_ready & ~bus.flush;

  always_comb begin
    w_direct_res = w_base;
    if (w_div_zero)     w_direct_res = w_is_rem ? bus.src_a : ONES;
    else if (w_div_ovf) w_direct_res = w_is_rem ? '0 : MIN_VAL;
  end

  // One radix-2 step. Multiply keeps {partial_hi, multiplier}; divide keeps {remainder, quotient}.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    w_div_diff  = w_div_shift - {1'b0, r_opnd};
    w_step_acc  = {w_mul_sum, r_acc[XLEN-1:1]};
    if (r_is_div) begin
      if (!w_div_diff[XLEN]) w_step_acc = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      else                   w_step_acc = {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    w_prod    = r_neg ? -w_step_acc : w_step_acc;
    w_div_val = r_is_rem ? w_step_acc[2*XLEN-1:XLEN] : w_step_acc[XLEN-1:0];
    if (r_is_div) w_fin_res = r_neg ? -w_div_val : w_div_val;
    else          w_fin_res = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_opnd      <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_is_rem    <= 1'b0;
      r_hi        <= 1'b0;
      r_neg       <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
          r_is_div   <= w_is_div;
          r_is_rem   <= w_is_rem;
          r_hi       <= w_hi;
          // Remainder follows the dividend's sign; product/quotient follow the sign difference.
          r_neg      <= w_is_rem ? w_a_neg : (w_a_neg ^ w_b_neg);
          if (w_start_calc) begin
            r_state <= CALC;
            r_cnt   <= SHW'(XLEN-1);
            r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
            r_acc   <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
          end else begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_direct_res;
          end
        end
        CALC: begin
          r_acc <= w_step_acc;
          if (r_cnt == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_fin_res;
          end else begin
            r_cnt <= r_cnt - SHW'(1);
          end
        end
        DONE: if (bus.out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_alu_seq_m.sv
// Self-checking bench for alu_seq_m: directed corner cases plus random ops
// compared cycle by cycle against an arithmetic reference model.
module tb_alu_seq_m;
  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_m_if #(.XLEN(XLEN)) bus ();

  alu_seq_m #(.XLEN(XLEN), .BAD_OP_VAL(32'hDEAD_BEEF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the op definitions.
  function automatic logic [31:0] model_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q;
    logic [63:0] ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a << b[4:0];
      5'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd3:  return (a < b) ? 32'd1 : 32'd0;
      5'd4:  return a ^ b;
      5'd5:  return a >> b[4:0];
      5'd6:  return a | b;
      5'd7:  return a & b;
      5'd8:  return a - b;
      5'd9:  return a;
      5'd13: return $unsigned($signed(a) >>> b[4:0]);
      5'd16: begin p = ua * ub; return p[31:0]; end
      5'd17: begin p = sa * sb; return p[63:32]; end
      5'd18: begin p = sa * ub; return p[63:32]; end
      5'd19: begin p = ua * ub; return p[63:32]; end
      5'd20: begin if (b == 0) return ONES; q = sa / sb; return q[31:0]; end
      5'd21: begin if (b == 0) return ONES; return a / b; end
      5'd22: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      5'd23: begin if (b == 0) return a; return a % b; end
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic int unsigned model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'd16 && op <= 5'd19) return 33;
    if (op >= 5'd20 && op <= 5'd23) begin
      if (b == 0) return 1;
      if ((op == 5'd20 || op == 5'd22) && a == MINV && b == ONES) return 1;
      return 33;
    end
    return 1;
  endfunction

  // Compare process: predicts every output on every negedge from the model.
  bit          m_pend = 0;
  logic [31:0] m_exp  = '0;
  logic [31:0] m_last = '0;
  int unsigned m_acc  = 0;
  int unsigned m_lat  = 0;

  initial begin : compare
    bit exp_v;
    forever begin
      @(negedge clk);
      exp_v = 1'b0;
      if (!rst_n) begin
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_result",    bus.result,         32'd0);
        m_pend = 0;
        m_last = '0;
      end else begin
        if (m_pend) begin
          exp_v = (cyc - m_acc) >= m_lat;
          check("out_valid", 32'(bus.out_valid), 32'(exp_v));
          check("busy",      32'(bus.busy),      32'd1);
          check("in_ready",  32'(bus.in_ready),  32'd0);
          if (exp_v) begin
            check("result", bus.result, m_exp);
            m_last = m_exp;
          end else begin
            check("result_hold", bus.result, m_last);
          end
        end else begin
          check("idle_out_valid", 32'(bus.out_valid), 32'd0);
          check("idle_busy",      32'(bus.busy),      32'd0);
          check("idle_in_ready",  32'(bus.in_ready),  32'd1);
          check("idle_result",    bus.result,         m_last);
        end
        if (bus.flush) m_pend = 0;
        else if (m_pend) begin
          if (exp_v && bus.out_ready) m_pend = 0;
        end else if (bus.in_valid) begin
          m_pend = 1;
          m_exp  = model_res(bus.op, bus.src_a, bus.src_b);
          m_lat  = model_lat(bus.op, bus.src_a, bus.src_b);
          m_acc  = cyc;
        end
      end
    end
  end

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit use_lit, input logic [31:0] lit);
    int n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.op = 5'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
    else if (use_lit) check($sformatf("lit_op%0d", op), bus.result, lit);
    repeat (hold) begin @(posedge clk); #1; end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return ONES;
      3: return MINV;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t        dirs[16];
  logic [4:0]  ops[19];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = '0; bus.src_a = '0; bus.src_b = '0;

    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd13,
            5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23};

    dirs = '{
      '{5'd0,  32'd5,          32'd7,          32'd12,         5},
      '{5'd13, 32'h8000_0000,  32'd4,          32'hF800_0000,  0},
      '{5'd17, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  0},
      '{5'd19, 32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  0},
      '{5'd16, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE,  0},
      '{5'd18, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  1},
      '{5'd20, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  0},
      '{5'd22, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  0},
      '{5'd21, 32'd100,        32'd7,          32'd14,         0},
      '{5'd23, 32'd100,        32'd7,          32'd2,          0},
      '{5'd21, 32'd10,         32'd0,          32'hFFFF_FFFF,  0},
      '{5'd22, 32'd10,         32'd0,          32'd10,         0},
      '{5'd20, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0},
      '{5'd22, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0},
      '{5'd2,  32'hFFFF_FFFF,  32'd1,          32'd1,          0},
      '{5'd3,  32'hFFFF_FFFF,  32'd1,          32'd0,          2}
    };

    // Hand-derived values pin the reference model itself.
    check("model_add",   model_res(5'd0,  32'd5, 32'd7), 32'd12);
    check("model_mulh",  model_res(5'd17, ONES, 32'd2),  32'hFFFF_FFFF);
    check("model_div",   model_res(5'd20, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("model_rem",   model_res(5'd22, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    check("model_lat_mul", model_lat(5'd16, ONES, 32'd2), 32'd33);
    check("model_lat_dz",  model_lat(5'd21, 32'd10, 32'd0), 32'd1);

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_busy",     32'(bus.busy),     32'd0);
    check("reset_result",   bus.result,        32'd0);
    rst_n = 1'b1;

    foreach (dirs[i]) run_op(dirs[i].op, dirs[i].a, dirs[i].b, dirs[i].hold, 1'b1, dirs[i].exp);

    // Flush partway through a multiply: no result may appear.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = 5'd17; bus.src_a = 32'h1234_5678; bus.src_b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_calc_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (40) @(posedge clk);
    #1;

    // Flush while holding a result: valid drops, result keeps its value.
    bus.in_valid = 1'b1; bus.op = 5'd0; bus.src_a = 32'd3; bus.src_b = 32'd4;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_done_valid",  32'(bus.out_valid), 32'd0);
    check("flush_done_result", bus.result,         32'd7);

    // Flush beats a simultaneous request.
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.op = 5'd8;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_no_accept", 32'(bus.busy), 32'd0);

    // Async reset mid-calculation.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = 5'd21; bus.src_a = $urandom; bus.src_b = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid",  32'(bus.out_valid), 32'd0);
    check("async_rst_busy",   32'(bus.busy),      32'd0);
    check("async_rst_result", bus.result,         32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(5'b01010, $urandom, $urandom, 0, 1'b1, 32'hDEAD_BEEF);

    for (int k = 0; k < 150; k++) begin
      logic [4:0] rop;
      if ($urandom_range(0, 9) < 8) rop = ops[$urandom_range(0, 18)];
      else                          rop = 5'($urandom);
      run_op(rop, pick_val(), pick_val(), $urandom_range(0, 2), 1'b0, 32'd0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
